// File: rtl/psram_responder_if.sv
// CellularRAM control pins between the initiator controller (master) and a responder bank (slave).
// The muxed cram_dq bus stays a plain inout on the responder so it can resolve against other banks.
interface psram_responder_if;
    logic [5:0] cram_a;
    logic       cram_clk;
    logic       cram_adv_n;
    logic       cram_cre;
    logic       cram_ce0_n;
    logic       cram_ce1_n;
    logic       cram_oe_n;
    logic       cram_we_n;
    logic       cram_ub_n;
    logic       cram_lb_n;
    logic       cram_wait;

    modport master (
        output cram_a, cram_clk, cram_adv_n, cram_cre, cram_ce0_n, cram_ce1_n,
               cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n,
        input  cram_wait
    );

    modport slave (
        input  cram_a, cram_clk, cram_adv_n, cram_cre, cram_ce0_n, cram_ce1_n,
               cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n,
        output cram_wait
    );
endinterface

// File: rtl/psram_responder.sv
// Responder model of one asynchronous address/data-muxed CellularRAM bank backed by a word RAM,
// with backdoor read port, access counters and a sticky protocol-error flag.
module psram_responder #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned BANK         = 0,
    parameter int unsigned READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    psram_responder_if.slave      bus,
    inout  wire  [15:0]           cram_dq,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [15:0]           dbg_data,
    output logic [15:0]           write_count,
    output logic [15:0]           read_count,
    output logic                  protocol_error
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ACCESS, ST_RD_WAIT, ST_RD_DRIVE, ST_WR
    } state_t;

    localparam logic [7:0] LAT_INIT = 8'(READ_LATENCY - 2);

    logic [5:0]  s_a_q;
    logic [15:0] s_dq_q;
    logic        s_adv_n_q, s_cre_q, s_ce0_n_q, s_ce1_n_q;
    logic        s_oe_n_q, s_we_n_q, s_ub_n_q, s_lb_n_q;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [1:0]            be_q, be_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  cfg_q, cfg_d;
    logic                  have_addr_q, have_addr_d;
    logic [15:0]           rd_data_q;

    logic [15:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic        ce, both_ce, rw_clash, adv_stray;
    logic        mem_we, rd_en, wc_inc, rc_inc, err_set;
    logic        drv_hi, drv_lo;
    logic [21:0] full_addr;
    logic        unused_bits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_a_q     <= '0;
            s_dq_q    <= '0;
            s_adv_n_q <= 1'b1;
            s_cre_q   <= 1'b0;
            s_ce0_n_q <= 1'b1;
            s_ce1_n_q <= 1'b1;
            s_oe_n_q  <= 1'b1;
            s_we_n_q  <= 1'b1;
            s_ub_n_q  <= 1'b1;
            s_lb_n_q  <= 1'b1;
        end else begin
            s_a_q     <= bus.cram_a;
            s_dq_q    <= cram_dq;
            s_adv_n_q <= bus.cram_adv_n;
            s_cre_q   <= bus.cram_cre;
            s_ce0_n_q <= bus.cram_ce0_n;
            s_ce1_n_q <= bus.cram_ce1_n;
            s_oe_n_q  <= bus.cram_oe_n;
            s_we_n_q  <= bus.cram_we_n;
            s_ub_n_q  <= bus.cram_ub_n;
            s_lb_n_q  <= bus.cram_lb_n;
        end
    end

    assign ce        = (BANK == 0) ? !s_ce0_n_q : !s_ce1_n_q;
    assign both_ce   = !s_ce0_n_q && !s_ce1_n_q;
    assign rw_clash  = ce && !s_oe_n_q && !s_we_n_q;
    assign adv_stray = ce && !s_adv_n_q && (state_q != ST_IDLE) && (state_q != ST_ADDR);
    assign full_addr = {s_a_q, s_dq_q};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cnt_d       = cnt_q;
        cfg_d       = cfg_q;
        have_addr_d = have_addr_q;
        mem_we      = 1'b0;
        rd_en       = 1'b0;
        wc_inc      = 1'b0;
        rc_inc      = 1'b0;
        err_set     = both_ce || rw_clash || adv_stray;
        unique case (state_q)
            ST_IDLE: begin
                if (ce && !s_adv_n_q) begin
                    state_d = ST_ADDR;
                    addr_d  = full_addr[ADDR_WIDTH-1:0];
                end else if (ce && !have_addr_q) begin
                    err_set = 1'b1;
                end
            end
            ST_ADDR: begin
                if (!ce) begin
                    state_d = ST_IDLE;
                end else if (!s_adv_n_q) begin
                    addr_d = full_addr[ADDR_WIDTH-1:0];
                end else begin
                    state_d     = ST_ACCESS;
                    have_addr_d = 1'b1;
                    // Config-register accesses are parked in ACCESS until deselect.
                    if (s_cre_q) begin
                        cfg_d   = 1'b1;
                        err_set = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (!ce) begin
                    state_d = ST_IDLE;
                    cfg_d   = 1'b0;
                end else if (!cfg_q && !rw_clash) begin
                    if (!s_we_n_q) begin
                        state_d = ST_WR;
                        wdata_d = s_dq_q;
                        be_d    = {!s_ub_n_q, !s_lb_n_q};
                    end else if (!s_oe_n_q) begin
                        state_d = ST_RD_WAIT;
                        cnt_d   = LAT_INIT;
                        rd_en   = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // Commit uses the capture from the sample before we_n rose.
                if (ce && !s_we_n_q) begin
                    wdata_d = s_dq_q;
                    be_d    = {!s_ub_n_q, !s_lb_n_q};
                end else begin
                    mem_we  = 1'b1;
                    wc_inc  = 1'b1;
                    state_d = ce ? ST_ACCESS : ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (!ce) begin
                    state_d = ST_IDLE;
                end else if (s_oe_n_q) begin
                    state_d = ST_ACCESS;
                end else if (cnt_q == '0) begin
                    state_d = ST_RD_DRIVE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RD_DRIVE: begin
                if (!ce || s_oe_n_q) begin
                    rc_inc  = 1'b1;
                    state_d = ce ? ST_ACCESS : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            cnt_q          <= '0;
            cfg_q          <= 1'b0;
            have_addr_q    <= 1'b0;
            dbg_data       <= '0;
            write_count    <= '0;
            read_count     <= '0;
            protocol_error <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            cnt_q          <= cnt_d;
            cfg_q          <= cfg_d;
            have_addr_q    <= have_addr_d;
            dbg_data       <= mem[dbg_addr];
            write_count    <= write_count + 16'(wc_inc);
            read_count     <= read_count + 16'(rc_inc);
            protocol_error <= protocol_error || err_set;
        end
    end

    // Backing store is not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we && be_q[1]) mem[addr_q][15:8] <= wdata_q[15:8];
        if (mem_we && be_q[0]) mem[addr_q][7:0]  <= wdata_q[7:0];
        if (rd_en) rd_data_q <= mem[addr_q];
    end

    assign drv_hi = (state_q == ST_RD_DRIVE) && !s_ub_n_q;
    assign drv_lo = (state_q == ST_RD_DRIVE) && !s_lb_n_q;
    assign cram_dq[15:8] = drv_hi ? rd_data_q[15:8] : 8'bz;
    assign cram_dq[7:0]  = drv_lo ? rd_data_q[7:0]  : 8'bz;

    assign bus.cram_wait = 1'b0;
    assign unused_bits   = ^{bus.cram_clk, full_addr[21:ADDR_WIDTH]};
endmodule

// File: tb/tb_psram_responder.sv
// Two responder banks on one shared cram bus, driven by a task-level initiator; reads are checked
// by a scoreboard monitor against a word-array model of both banks.
module tb_psram_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #4 clk = ~clk;

    psram_responder_if bus0 ();
    psram_responder_if bus1 ();

    wire  [15:0] cram_dq;
    logic [15:0] tb_dq;
    logic        tb_dq_en;
    pullup pu_dq (cram_dq);
    assign cram_dq = tb_dq_en ? tb_dq : 16'bz;

    logic [5:0] c_a;
    logic c_adv_n, c_cre, c_ce0_n, c_ce1_n, c_oe_n, c_we_n, c_ub_n, c_lb_n;

    assign bus0.cram_a = c_a;         assign bus1.cram_a = c_a;
    assign bus0.cram_clk = clk;       assign bus1.cram_clk = clk;
    assign bus0.cram_adv_n = c_adv_n; assign bus1.cram_adv_n = c_adv_n;
    assign bus0.cram_cre = c_cre;     assign bus1.cram_cre = c_cre;
    assign bus0.cram_ce0_n = c_ce0_n; assign bus1.cram_ce0_n = c_ce0_n;
    assign bus0.cram_ce1_n = c_ce1_n; assign bus1.cram_ce1_n = c_ce1_n;
    assign bus0.cram_oe_n = c_oe_n;   assign bus1.cram_oe_n = c_oe_n;
    assign bus0.cram_we_n = c_we_n;   assign bus1.cram_we_n = c_we_n;
    assign bus0.cram_ub_n = c_ub_n;   assign bus1.cram_ub_n = c_ub_n;
    assign bus0.cram_lb_n = c_lb_n;   assign bus1.cram_lb_n = c_lb_n;

    logic [9:0]  dbg_addr0, dbg_addr1;
    logic [15:0] dbg_data0, dbg_data1, wc0, wc1, rc0, rc1;
    logic        err0, err1;

    psram_responder #(.ADDR_WIDTH(10), .BANK(0), .READ_LATENCY(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .cram_dq(cram_dq),
        .dbg_addr(dbg_addr0), .dbg_data(dbg_data0), .write_count(wc0),
        .read_count(rc0), .protocol_error(err0)
    );
    psram_responder #(.ADDR_WIDTH(10), .BANK(1), .READ_LATENCY(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .cram_dq(cram_dq),
        .dbg_addr(dbg_addr1), .dbg_data(dbg_data1), .write_count(wc1),
        .read_count(rc1), .protocol_error(err1)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] model [2][1024];
    logic [15:0] exp_q [$];
    logic        rd_strobe = 1'b0;
    logic [15:0] mon_exp;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: consumes one expected word per read data phase presented on the bus.
    always @(posedge clk) begin
        #1;
        if (rd_strobe) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data: got %h expected <no entry queued>", cram_dq);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cram_dq !== mon_exp) begin
                    errors++;
                    $display("FAIL rd_data: got %h expected %h", cram_dq, mon_exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_bus();
        c_ce0_n = 1'b1; c_ce1_n = 1'b1; c_adv_n = 1'b1; c_oe_n = 1'b1; c_we_n = 1'b1;
        c_ub_n = 1'b1; c_lb_n = 1'b1; c_cre = 1'b0; tb_dq_en = 1'b0;
    endtask

    task automatic addr_phase(input int bank, input logic [21:0] a, input logic cre);
        @(negedge clk);
        if (bank == 0) c_ce0_n = 1'b0; else c_ce1_n = 1'b0;
        c_adv_n = 1'b0; c_cre = cre; c_a = a[21:16]; tb_dq = a[15:0]; tb_dq_en = 1'b1;
        cyc(2);
        c_adv_n = 1'b1; tb_dq_en = 1'b0;
    endtask

    task automatic cram_write(input int bank, input logic [21:0] a, input logic [15:0] d,
                              input logic ub_n, input logic lb_n, input logic cre);
        addr_phase(bank, a, cre);
        c_we_n = 1'b0; c_ub_n = ub_n; c_lb_n = lb_n; tb_dq = d; tb_dq_en = 1'b1;
        cyc(3);
        c_we_n = 1'b1; tb_dq_en = 1'b0;
        cyc(3);
        if (!cre) begin
            if (!ub_n) model[bank][a[9:0]][15:8] = d[15:8];
            if (!lb_n) model[bank][a[9:0]][7:0]  = d[7:0];
        end
        idle_bus();
        cyc(2);
    endtask

    task automatic cram_read(input int bank, input logic [21:0] a, input logic ub_n,
                             input logic lb_n, input logic mid_reset);
        logic [15:0] m;
        addr_phase(bank, a, 1'b0);
        cyc(1);
        c_oe_n = 1'b0; c_ub_n = ub_n; c_lb_n = lb_n;
        cyc(4);
        check("rd_before_latency", cram_dq, 16'hFFFF);
        cyc(1);
        m = model[bank][a[9:0]];
        exp_q.push_back({ub_n ? 8'hFF : m[15:8], lb_n ? 8'hFF : m[7:0]});
        rd_strobe = 1'b1;
        cyc(1);
        rd_strobe = 1'b0;
        if (mid_reset) begin
            reset_n = 1'b0;
            #1;
            check("reset_release_dq", cram_dq, 16'hFFFF);
            idle_bus();
            cyc(2);
            reset_n = 1'b1;
            cyc(2);
        end else begin
            c_oe_n = 1'b1;
            cyc(2);
            check("rd_turnaround", cram_dq, 16'hFFFF);
            idle_bus();
            cyc(2);
        end
    endtask

    logic [21:0] wa, ra;
    logic [15:0] wd;
    logic [21:0] written [$];
    int unsigned sel;

    initial begin
        idle_bus();
        c_a = '0; tb_dq = '0; dbg_addr0 = '0; dbg_addr1 = '0;
        cyc(3);
        check("reset_wc0", wc0, 16'd0);
        check("reset_rc0", rc0, 16'd0);
        check("reset_err0", {15'd0, err0}, 16'd0);
        check("reset_dbg0", dbg_data0, 16'd0);
        check("reset_wait", {15'd0, bus0.cram_wait}, 16'd0);
        check("reset_dq_z", cram_dq, 16'hFFFF);
        reset_n = 1'b1;
        cyc(2);

        cram_write(0, 22'h000123, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        cram_read(0, 22'h000123, 1'b0, 1'b0, 1'b0);
        check("wc0_after_word", wc0, 16'd1);
        check("rc0_after_word", rc0, 16'd1);
        check("wc1_other_bank", wc1, 16'd0);
        dbg_addr0 = 10'h123;
        cyc(2);
        check("dbg0_0x123", dbg_data0, 16'hBEEF);

        cram_write(0, 22'h000010, 16'h1234, 1'b0, 1'b0, 1'b0);
        cram_write(0, 22'h000010, 16'hABCD, 1'b0, 1'b1, 1'b0);
        cram_read(0, 22'h000010, 1'b0, 1'b0, 1'b0);
        cram_read(0, 22'h000010, 1'b1, 1'b0, 1'b0);

        cram_write(1, 22'h3F0400, 16'h5555, 1'b0, 1'b0, 1'b0);
        check("wc1_alias", wc1, 16'd1);
        check("wc0_unchanged", wc0, 16'd3);
        dbg_addr1 = 10'h000;
        cyc(2);
        check("dbg1_alias", dbg_data1, 16'h5555);
        cram_read(1, 22'h000000, 1'b0, 1'b0, 1'b0);

        check("err0_clean", {15'd0, err0}, 16'd0);
        addr_phase(0, 22'h000123, 1'b0);
        c_oe_n = 1'b0; c_we_n = 1'b0; tb_dq = 16'hDEAD; tb_dq_en = 1'b1;
        cyc(4);
        idle_bus();
        cyc(3);
        check("err0_oe_we", {15'd0, err0}, 16'd1);
        check("wc0_no_commit", wc0, 16'd3);
        cyc(1);
        check("dbg0_unchanged", dbg_data0, 16'hBEEF);

        check("err1_clean", {15'd0, err1}, 16'd0);
        cram_write(1, 22'h000000, 16'h7777, 1'b0, 1'b0, 1'b1);
        check("err1_cre", {15'd0, err1}, 16'd1);
        check("wc1_cre", wc1, 16'd1);
        cyc(1);
        check("dbg1_cre", dbg_data1, 16'h5555);

        cram_read(0, 22'h000123, 1'b0, 1'b0, 1'b1);
        check("post_reset_wc0", wc0, 16'd0);
        check("post_reset_rc0", rc0, 16'd0);
        check("post_reset_err0", {15'd0, err0}, 16'd0);
        check("post_reset_wc1", wc1, 16'd0);
        check("post_reset_err1", {15'd0, err1}, 16'd0);
        cram_read(0, 22'h000123, 1'b0, 1'b0, 1'b0);

        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        for (int i = 0; i < 128; i++) begin
            wa = 22'($urandom);
            wd = 16'($urandom);
            cram_write(0, wa, wd, 1'b0, 1'b0, 1'b0);
            written.push_back(wa);
            ra = written[$urandom_range(0, written.size() - 1)];
            ra = {12'($urandom), ra[9:0]};
            sel = $urandom_range(0, 2);
            cram_read(0, ra, sel == 2, sel == 1, 1'b0);
        end
        check("rand_wc0", wc0, 16'd128);
        check("rand_rc0", rc0, 16'd128);
        check("rand_err0", {15'd0, err0}, 16'd0);
        check("rand_rc1", rc1, 16'd0);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/psram_responder.md
# psram_responder

Synthesizable responder model of one asynchronous, address/data-muxed CellularRAM bank. It decodes the `cram_*` bus driven by the team's PSRAM initiator controller, latches the 22-bit address from `{cram_a, cram_dq}`, and commits writes into an internal block-RAM word array. It answers reads by driving `cram_dq`. It sits in simulation and loopback benches opposite the controller, and exposes a backdoor read port, access counters and a sticky protocol-error flag for checking.

## Interface
- `ADDR_WIDTH`, 10: word-address bits of the backing store (1024 × 16). Address bits `[21:ADDR_WIDTH]` are ignored, so accesses alias.
- `BANK`, 0: selects which chip enable the block responds to. 0 uses `cram_ce0_n`; 1 uses `cram_ce1_n`.
- `READ_LATENCY`, 4: cycles from the edge where `oe_n` is first sampled low to the first cycle `cram_dq` is driven. Must be ≥ 2.
- `clk`  in  1  sole clock; all inputs are sampled on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cram_a`  in  6  address bits `[21:16]`.
- `cram_dq`  inout  16  muxed address/data bus. The block drives it only during read data phase; otherwise `cram_dq` is high-Z.
- `cram_wait`  out  1  tied 0 (async mode).
- `cram_clk`  in  1  ignored.
- `cram_adv_n`, `cram_cre`, `cram_ce0_n`, `cram_ce1_n`, `cram_oe_n`, `cram_we_n`, `cram_ub_n`, `cram_lb_n`  in  1 each  initiator controls.
- `dbg_addr`  in  ADDR_WIDTH  backdoor word address.
- `dbg_data`  out  16  backdoor read data, 1-cycle registered.
- `write_count`  out  16  committed writes, wrapping.
- `read_count`  out  16  completed read data phases, wrapping.
- `protocol_error`  out  1  sticky error flag; cleared only by reset.

## Operation
- **Input sampling.** Every edge registers all control inputs and `cram_dq` into `s_*`. The FSM acts only on `s_*`. `ce` means the `BANK`-selected enable is sampled low.
- **States:** IDLE, ADDR, ACCESS, RD_WAIT, RD_DRIVE, WR.
- **IDLE.**
  - `ce` and `adv_n` low → ADDR.
  - `ce` with `adv_n` high and no prior address → `protocol_error`; stay in IDLE.
- **ADDR.**
  - Each cycle, latches `addr <= {s_a, s_dq}[ADDR_WIDTH-1:0]`, so the last sample before `adv_n` rises wins.
  - `adv_n` high → ACCESS.
  - If `s_cre` is high at the `adv_n` rise, the access is a config-register access. The block ignores it (no write, no drive), sets `protocol_error`, and waits for `ce` high.
- **ACCESS.**
  - `we_n` low → WR.
  - `oe_n` low → RD_WAIT, loading the latency counter.
  - `ce` high → IDLE.
- **WR.**
  - Each cycle, captures `wdata <= s_dq`, `be <= {~s_ub_n, ~s_lb_n}`.
  - Sampled `we_n` rising, or `ce` rising while `we_n` low, commits `wdata` per byte to `mem[addr]` on that edge. It then increments `write_count` and goes to ACCESS (or IDLE if `ce` is high).
  - Captures use the previous sample, so data released in the same cycle as `we_n` still commits correctly.
- **RD_WAIT.**
  - Issues a synchronous RAM read of `mem[addr]` on entry.
  - Counter reaching zero → RD_DRIVE.
- **RD_DRIVE.**
  - Drives `cram_dq` per byte: high byte when `~s_ub_n`, low byte when `~s_lb_n`. A disabled byte is high-Z.
  - Exits when `oe_n` or `ce` is sampled high. Releases `cram_dq` on the next edge, increments `read_count`, and goes to ACCESS or IDLE respectively.
- **Protocol errors** (set `protocol_error`, no state change): `oe_n` and `we_n` both low while `ce`; `adv_n` low outside IDLE/ADDR with `ce` held; both chip enables low.
- **Early exit.** `ce` rising in RD_WAIT → IDLE; no drive, no count.
- **Reset** (any state) has these effects:
  - FSM goes to IDLE and `cram_dq` is released immediately (asynchronously).
  - `dbg_data`, `write_count`, `read_count`, `protocol_error` and `cram_wait` are 0.
  - Memory contents are preserved.
- **Backdoor.** `dbg_data <= mem[dbg_addr]` every cycle. On the port conflicting with a write commit to the same address, `dbg_data` returns old data.

## Timing
- Input-to-FSM: 1 cycle (sample register).
- Address capture: the value present 1 edge before `adv_n` is sampled high.
- Write commit: the edge where `we_n` is sampled high, i.e. 2 edges after the pin rise. `mem` is visible to a later read from the following cycle.
- Read: data is driven `READ_LATENCY` edges after `oe_n` is first sampled low. The initiator at 133 MHz samples ≥ 6 cycles after `oe_n`, so default 4 meets it.
- Bus turnaround: `cram_dq` is high-Z no later than 2 edges after the `oe_n` pin rises.
- Counters wrap `16'hFFFF → 0`.

## Test plan
- **Word write/read back.** Write `0xBEEF` to address `0x000123` (both bytes), then read `0x000123`. Required: `cram_dq = 0xBEEF` during RD_DRIVE; `write_count = 1`, `read_count = 1`; `dbg_data = 0xBEEF` at `dbg_addr = 0x123`.
- **Byte enables.** Fill `0x0010` with `0x1234`, then write `0xABCD` with only `ub_n` low. Required: readback `0xAB34`. A read with only `lb_n` low drives the low byte `0x34` and leaves the high byte Z.
- **Aliasing and bank select.** With `BANK = 1`, write via `ce0_n` → no commit, `write_count = 0`. Write `0x5555` via `ce1_n` to `0x3F0400`. Required: `dbg_addr = 0x000` reads `0x5555`.
- **Errors.** Assert `oe_n` and `we_n` low together. Required: `protocol_error = 1`, memory unchanged. Separately, a CRE-high access sets the flag and commits no write.
- **Reset mid-read.** Pull `reset_n` low during RD_DRIVE. Required: `cram_dq` is Z immediately; counters are 0; memory still returns the prior value after reset.
- **Back-to-back traffic.** 256 alternating random writes and reads from the controller at 133.12 MHz. Required: every read matches a scoreboard; `read_count = write_count = 128`; `protocol_error = 0`.
